// File: rtl/sys_ctrl_ahbl_regs.sv
// AHB-Lite register file holding the system-control configuration fields that feed sys_ctrl_regs,
// plus a synchronised, read-only view of the mgmt_select status.
module sys_ctrl_ahbl_regs #(
    parameter int ADDR_W    = 12,
    parameter bit MGMT_SYNC = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    input  logic [31:0]       HWDATA,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [23:0]       bus_muxsplit,
    output logic              bus_vref_e_vrefgen_en,
    output logic              bus_vref_w_vrefgen_en,
    output logic [4:0]        bus_vref_e_ref_sel,
    output logic [4:0]        bus_vref_w_ref_sel,
    output logic              bus_user_ahb_enable,
    output logic [15:0]       bus_user_irqs_enable,
    output logic [5:0]        bus_sio_cfg,
    input  logic              bus_mgmt_select
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  off_q, off_d;
    logic [3:0]  lanes_q, lanes_d;
    logic        wr_q, wr_d;
    logic        hreadyout_q, hreadyout_d;
    logic        hresp_q, hresp_d;
    logic [23:0] muxsplit_q, muxsplit_d;
    logic        vref_e_en_q, vref_e_en_d;
    logic        vref_w_en_q, vref_w_en_d;
    logic [4:0]  vref_e_sel_q, vref_e_sel_d;
    logic [4:0]  vref_w_sel_q, vref_w_sel_d;
    logic        user_ahb_en_q, user_ahb_en_d;
    logic [15:0] user_irqs_q, user_irqs_d;
    logic [5:0]  sio_cfg_q, sio_cfg_d;
    logic [31:0] scratch_q, scratch_d;
    logic        mgmt_meta_q, mgmt_meta_d;
    logic        mgmt_sync_q, mgmt_sync_d;

    logic        addr_valid_s;
    logic        size_ok_s;
    logic        legal_s;
    logic [3:0]  lane_s;
    logic        mgmt_rd_s;
    logic [31:0] rd_word_s;
    logic [31:0] bmask_s;
    logic [31:0] wmerge_s;
    logic [2:0]  wr_sel_s;
    logic [31:0] hrdata_s;
    logic        unused_s;

    assign unused_s     = ^{HTRANS[0], HADDR[ADDR_W-1:5]};
    assign addr_valid_s = HSEL & HTRANS[1] & HREADY;
    assign mgmt_rd_s    = MGMT_SYNC ? mgmt_sync_q : mgmt_meta_q;

    // Address-phase decode: byte-lane mask, alignment check and offset range check.
    always_comb begin
        case (HSIZE)
            3'd0: begin
                lane_s    = 4'b0001 << HADDR[1:0];
                size_ok_s = 1'b1;
            end
            3'd1: begin
                lane_s    = HADDR[1] ? 4'b1100 : 4'b0011;
                size_ok_s = ~HADDR[0];
            end
            3'd2: begin
                lane_s    = 4'b1111;
                size_ok_s = (HADDR[1:0] == 2'b00);
            end
            default: begin
                lane_s    = 4'b0000;
                size_ok_s = 1'b0;
            end
        endcase
        legal_s = size_ok_s && (HADDR[4:2] <= 3'd4);
    end

    // Register word view of the latched offset, shared by readback and write merging.
    always_comb begin
        case (off_q)
            3'd0:    rd_word_s = {8'd0, muxsplit_q};
            3'd1:    rd_word_s = {11'd0, vref_w_sel_q, 3'd0, vref_e_sel_q, 6'd0, vref_w_en_q, vref_e_en_q};
            3'd2:    rd_word_s = {user_irqs_q, 15'd0, user_ahb_en_q};
            3'd3:    rd_word_s = {23'd0, mgmt_rd_s, 2'b00, sio_cfg_q};
            3'd4:    rd_word_s = scratch_q;
            default: rd_word_s = 32'd0;
        endcase
    end

    // Read data is only driven during a read data phase.
    always_comb begin
        if ((state_q == ST_DATA) && !wr_q) begin
            hrdata_s = rd_word_s;
        end else begin
            hrdata_s = 32'd0;
        end
    end

    // Byte-lane merge of write data; the write commits on the edge that ends the data phase.
    always_comb begin
        bmask_s  = {{8{lanes_q[3]}}, {8{lanes_q[2]}}, {8{lanes_q[1]}}, {8{lanes_q[0]}}};
        wmerge_s = (rd_word_s & ~bmask_s) | (HWDATA & bmask_s);
        wr_sel_s = ((state_q == ST_DATA) && wr_q) ? off_q : 3'd7;

        muxsplit_d    = muxsplit_q;
        vref_e_en_d   = vref_e_en_q;
        vref_w_en_d   = vref_w_en_q;
        vref_e_sel_d  = vref_e_sel_q;
        vref_w_sel_d  = vref_w_sel_q;
        user_ahb_en_d = user_ahb_en_q;
        user_irqs_d   = user_irqs_q;
        sio_cfg_d     = sio_cfg_q;
        scratch_d     = scratch_q;
        case (wr_sel_s)
            3'd0: muxsplit_d = wmerge_s[23:0];
            3'd1: begin
                vref_e_en_d  = wmerge_s[0];
                vref_w_en_d  = wmerge_s[1];
                vref_e_sel_d = wmerge_s[12:8];
                vref_w_sel_d = wmerge_s[20:16];
            end
            3'd2: begin
                user_ahb_en_d = wmerge_s[0];
                user_irqs_d   = wmerge_s[31:16];
            end
            3'd3:    sio_cfg_d = wmerge_s[5:0];
            3'd4:    scratch_d = wmerge_s;
            default: scratch_d = scratch_q;
        endcase
    end

    // Transfer FSM next state; ERR1 ignores the bus since HREADY is low then.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        lanes_d = lanes_q;
        wr_d    = wr_q;
        case (state_q)
            ST_ERR1: state_d = ST_ERR2;
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (addr_valid_s && legal_s) begin
                    state_d = ST_DATA;
                    off_d   = HADDR[4:2];
                    lanes_d = lane_s;
                    wr_d    = HWRITE;
                end else if (addr_valid_s) begin
                    state_d = ST_ERR1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        hreadyout_d = (state_d != ST_ERR1);
        hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
        mgmt_meta_d = bus_mgmt_select;
        mgmt_sync_d = mgmt_meta_q;
    end

    // All state, with synchronous reset taking priority over any pending write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            off_q         <= 3'd0;
            lanes_q       <= 4'd0;
            wr_q          <= 1'b0;
            hreadyout_q   <= 1'b1;
            hresp_q       <= 1'b0;
            muxsplit_q    <= 24'd0;
            vref_e_en_q   <= 1'b0;
            vref_w_en_q   <= 1'b0;
            vref_e_sel_q  <= 5'd0;
            vref_w_sel_q  <= 5'd0;
            user_ahb_en_q <= 1'b0;
            user_irqs_q   <= 16'd0;
            sio_cfg_q     <= 6'd0;
            scratch_q     <= 32'd0;
            mgmt_meta_q   <= 1'b0;
            mgmt_sync_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            off_q         <= off_d;
            lanes_q       <= lanes_d;
            wr_q          <= wr_d;
            hreadyout_q   <= hreadyout_d;
            hresp_q       <= hresp_d;
            muxsplit_q    <= muxsplit_d;
            vref_e_en_q   <= vref_e_en_d;
            vref_w_en_q   <= vref_w_en_d;
            vref_e_sel_q  <= vref_e_sel_d;
            vref_w_sel_q  <= vref_w_sel_d;
            user_ahb_en_q <= user_ahb_en_d;
            user_irqs_q   <= user_irqs_d;
            sio_cfg_q     <= sio_cfg_d;
            scratch_q     <= scratch_d;
            mgmt_meta_q   <= mgmt_meta_d;
            mgmt_sync_q   <= mgmt_sync_d;
        end
    end

    assign HRDATA                = hrdata_s;
    assign HREADYOUT             = hreadyout_q;
    assign HRESP                 = hresp_q;
    assign bus_muxsplit          = muxsplit_q;
    assign bus_vref_e_vrefgen_en = vref_e_en_q;
    assign bus_vref_w_vrefgen_en = vref_w_en_q;
    assign bus_vref_e_ref_sel    = vref_e_sel_q;
    assign bus_vref_w_ref_sel    = vref_w_sel_q;
    assign bus_user_ahb_enable   = user_ahb_en_q;
    assign bus_user_irqs_enable  = user_irqs_q;
    assign bus_sio_cfg           = sio_cfg_q;

endmodule

// File: tb/tb_sys_ctrl_ahbl_regs.sv
// Self-checking bench for sys_ctrl_ahbl_regs: reference register model plus a read-data scoreboard.
module tb_sys_ctrl_ahbl_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        HSEL;
    logic [11:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [23:0] bus_muxsplit;
    logic        bus_vref_e_vrefgen_en;
    logic        bus_vref_w_vrefgen_en;
    logic [4:0]  bus_vref_e_ref_sel;
    logic [4:0]  bus_vref_w_ref_sel;
    logic        bus_user_ahb_enable;
    logic [15:0] bus_user_irqs_enable;
    logic [5:0]  bus_sio_cfg;
    logic        bus_mgmt_select;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] IMPL [0:4] = '{32'h00FF_FFFF, 32'h001F_1F03, 32'hFFFF_0001,
                                          32'h0000_003F, 32'hFFFF_FFFF};
    logic [31:0] model [0:4];
    logic        mgmt_m;
    logic [31:0] sb_q [$];

    sys_ctrl_ahbl_regs #(.ADDR_W(12), .MGMT_SYNC(1'b1)) dut (
        .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .bus_muxsplit(bus_muxsplit),
        .bus_vref_e_vrefgen_en(bus_vref_e_vrefgen_en),
        .bus_vref_w_vrefgen_en(bus_vref_w_vrefgen_en),
        .bus_vref_e_ref_sel(bus_vref_e_ref_sel),
        .bus_vref_w_ref_sel(bus_vref_w_ref_sel),
        .bus_user_ahb_enable(bus_user_ahb_enable),
        .bus_user_irqs_enable(bus_user_irqs_enable),
        .bus_sio_cfg(bus_sio_cfg),
        .bus_mgmt_select(bus_mgmt_select)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HADDR  = 12'h000;
        HSIZE  = 3'd2;
        HREADY = 1'b1;
    endtask

    task automatic addr_phase(input logic [11:0] a, input logic [2:0] sz, input logic wr);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = wr;
        HADDR  = a;
        HSIZE  = sz;
        HREADY = 1'b1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) model[i] = 32'd0;
        mgmt_m = 1'b0;
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] off);
        if (off == 3'd3) return model[3] | {23'd0, mgmt_m, 8'd0};
        return model[off];
    endfunction

    function automatic void model_wr(input logic [11:0] a, input logic [2:0] sz, input logic [31:0] d);
        logic [3:0]  ln;
        logic [31:0] bm;
        logic [2:0]  off;
        case (sz)
            3'd0:    ln = 4'b0001 << a[1:0];
            3'd1:    ln = a[1] ? 4'b1100 : 4'b0011;
            default: ln = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) bm[8*i +: 8] = {8{ln[i]}};
        off = a[4:2];
        model[off] = ((model[off] & ~bm) | (d & bm)) & IMPL[off];
    endfunction

    task automatic do_write(input logic [11:0] a, input logic [2:0] sz, input logic [31:0] d);
        addr_phase(a, sz, 1'b1);
        step();
        bus_idle();
        HWDATA = d;
        n_vec++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            n_err++;
            $display("FAIL write_resp addr=%h got rdy=%b resp=%b need rdy=1 resp=0", a, HREADYOUT, HRESP);
        end
        model_wr(a, sz, d);
        step();
    endtask

    task automatic do_read(input logic [11:0] a);
        logic [31:0] exp;
        sb_q.push_back(model_rd(a[4:2]));
        addr_phase(a, 3'd2, 1'b0);
        step();
        bus_idle();
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL read_sb addr=%h scoreboard empty", a);
        end else begin
            exp = sb_q.pop_front();
            if (HRDATA !== exp) begin
                n_err++;
                $display("FAIL read addr=%h got %h need %h", a, HRDATA, exp);
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        HWDATA = 32'd0;
        bus_mgmt_select = 1'b0;
        model_reset();
        step();
        step();
        rst = 1'b0;
        n_vec++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'd0) begin
            n_err++;
            $display("FAIL reset_bus got rdy=%b resp=%b rdata=%h need 1 0 0", HREADYOUT, HRESP, HRDATA);
        end
        n_vec++;
        if ({bus_muxsplit, bus_vref_e_vrefgen_en, bus_vref_w_vrefgen_en, bus_vref_e_ref_sel,
             bus_vref_w_ref_sel, bus_user_ahb_enable, bus_user_irqs_enable, bus_sio_cfg} !== 60'd0) begin
            n_err++;
            $display("FAIL reset_outs got mux=%h sio=%h irqs=%h need 0", bus_muxsplit, bus_sio_cfg,
                     bus_user_irqs_enable);
        end
        for (int i = 0; i < 5; i++) do_read(12'(4 * i));
    endtask

    task automatic test_word();
        do_write(12'h000, 3'd2, 32'h00A5_5A5A);
        n_vec++;
        if (bus_muxsplit !== 24'hA55A5A) begin
            n_err++;
            $display("FAIL muxsplit_out got %h need a55a5a", bus_muxsplit);
        end
        do_read(12'h000);
        do_write(12'h004, 3'd2, 32'hFFFF_FFFF);
        n_vec++;
        if ({bus_vref_e_vrefgen_en, bus_vref_w_vrefgen_en, bus_vref_e_ref_sel, bus_vref_w_ref_sel}
            !== 12'hFFF) begin
            n_err++;
            $display("FAIL vref_out got e=%b w=%b es=%h ws=%h need all ones", bus_vref_e_vrefgen_en,
                     bus_vref_w_vrefgen_en, bus_vref_e_ref_sel, bus_vref_w_ref_sel);
        end
        do_read(12'h004);
    endtask

    task automatic test_lanes();
        do_write(12'h008, 3'd2, 32'h0000_0001);
        do_write(12'h00A, 3'd0, 32'hAA3C_55FE);
        n_vec++;
        if (bus_user_irqs_enable !== 16'h003C || bus_user_ahb_enable !== 1'b1) begin
            n_err++;
            $display("FAIL byte_lane got irqs=%h ahb=%b need 003c 1", bus_user_irqs_enable,
                     bus_user_ahb_enable);
        end
        do_read(12'h008);
        do_write(12'h012, 3'd1, 32'hBEEF_1234);
        do_read(12'h010);
    endtask

    task automatic err_xfer(input logic [11:0] a, input logic [2:0] sz);
        addr_phase(a, sz, 1'b1);
        step();
        HWDATA = 32'hFFFF_FFFF;
        addr_phase(12'h010, 3'd2, 1'b1);
        HREADY = 1'b0;
        n_vec++;
        if (HREADYOUT !== 1'b0 || HRESP !== 1'b1) begin
            n_err++;
            $display("FAIL err1 addr=%h got rdy=%b resp=%b need 0 1", a, HREADYOUT, HRESP);
        end
        step();
        bus_idle();
        n_vec++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b1) begin
            n_err++;
            $display("FAIL err2 addr=%h got rdy=%b resp=%b need 1 1", a, HREADYOUT, HRESP);
        end
        step();
        n_vec++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            n_err++;
            $display("FAIL err_done addr=%h got rdy=%b resp=%b need 1 0", a, HREADYOUT, HRESP);
        end
    endtask

    task automatic test_errors();
        err_xfer(12'h014, 3'd2);
        err_xfer(12'h001, 3'd1);
        err_xfer(12'h010, 3'd3);
        err_xfer(12'h01C, 3'd2);
        for (int i = 0; i < 5; i++) do_read(12'(4 * i));
    endtask

    task automatic test_idle();
        HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 12'h010; HSIZE = 3'd2; HREADY = 1'b1;
        step();
        HWDATA = 32'h1234_5678;
        HSEL = 1'b0; HTRANS = 2'b10;
        n_vec++;
        if (HRDATA !== 32'd0 || HRESP !== 1'b0) begin
            n_err++;
            $display("FAIL idle_xfer got rdata=%h resp=%b need 0 0", HRDATA, HRESP);
        end
        step();
        HWDATA = 32'h8765_4321;
        HSEL = 1'b1; HTRANS = 2'b01;
        n_vec++;
        if (HRDATA !== 32'd0 || HRESP !== 1'b0) begin
            n_err++;
            $display("FAIL unsel_xfer got rdata=%h resp=%b need 0 0", HRDATA, HRESP);
        end
        step();
        bus_idle();
        HWDATA = 32'hCAFE_F00D;
        step();
        do_read(12'h010);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        addr_phase(12'h00C, 3'd2, 1'b1);
        step();
        HWDATA = 32'h0000_0015;
        model_wr(12'h00C, 3'd2, 32'h0000_0015);
        sb_q.push_back(model_rd(3'd3));
        addr_phase(12'h00C, 3'd2, 1'b0);
        step();
        bus_idle();
        exp = sb_q.pop_front();
        n_vec++;
        if (HRDATA !== exp) begin
            n_err++;
            $display("FAIL b2b_read got %h need %h", HRDATA, exp);
        end
        n_vec++;
        if (bus_sio_cfg !== 6'h15) begin
            n_err++;
            $display("FAIL b2b_sio got %h need 15", bus_sio_cfg);
        end
        step();
    endtask

    task automatic test_mgmt();
        logic [31:0] exp;
        bus_mgmt_select = 1'b1;
        sb_q.push_back(model_rd(3'd3));
        addr_phase(12'h00C, 3'd2, 1'b0);
        step();
        exp = sb_q.pop_front();
        n_vec++;
        if (HRDATA !== exp) begin
            n_err++;
            $display("FAIL mgmt_1cyc got %h need %h", HRDATA, exp);
        end
        mgmt_m = 1'b1;
        sb_q.push_back(model_rd(3'd3));
        addr_phase(12'h00C, 3'd2, 1'b0);
        step();
        bus_idle();
        exp = sb_q.pop_front();
        n_vec++;
        if (HRDATA !== exp) begin
            n_err++;
            $display("FAIL mgmt_2cyc got %h need %h", HRDATA, exp);
        end
        step();
        do_write(12'h00C, 3'd2, 32'h0000_002A);
        do_read(12'h00C);
    endtask

    task automatic test_reset_abort();
        addr_phase(12'h010, 3'd2, 1'b1);
        step();
        HWDATA = 32'hDEAD_BEEF;
        bus_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        n_vec++;
        if (bus_muxsplit !== 24'd0 || bus_sio_cfg !== 6'd0 || HREADYOUT !== 1'b1) begin
            n_err++;
            $display("FAIL abort_outs got mux=%h sio=%h rdy=%b need 0 0 1", bus_muxsplit, bus_sio_cfg,
                     HREADYOUT);
        end
        do_read(12'h010);
        do_read(12'h000);
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_errors();
        test_idle();
        test_back_to_back();
        test_mgmt();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sys_ctrl_ahbl_regs.md
# sys_ctrl_ahbl_regs

AHB-Lite slave register file that holds the system-control configuration fields: bus-split mux switches, VREF generator controls, user AHB/IRQ enables and SIO configuration. Its registered outputs drive the `bus_*` inputs of `sys_ctrl_regs`, the system-control fan-out stage, one for one. The external `mgmt_select` status, returned by `sys_ctrl_regs` on `bus_mgmt_select`, is synchronised here and made readable. Single clock, zero-wait-state for legal accesses, two-cycle ERROR for illegal ones.

## Interface
- ADDR_W, 12, width of HADDR; only HADDR[4:0] decoded, upper bits ignored (window selected by HSEL)
- MGMT_SYNC, 1, 1 = 2-flop synchroniser on mgmt_select; 0 = single register stage
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- HSEL  in  1  slave select
- HADDR  in  ADDR_W  byte address
- HTRANS  in  2  transfer type; NONSEQ/SEQ (bit1=1) are active
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 byte, 1 halfword, 2 word; larger is illegal
- HREADY  in  1  bus ready (address phase accepted when high)
- HWDATA  in  32  write data (data phase)
- HRDATA  out  32  read data (data phase)
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 OKAY, 1 ERROR
- bus_muxsplit  out  24  switch bits; per corner {aa_sr,bb_sr,bb_sl,bb_s0,aa_s0,aa_sl} at [5:0] se, [11:6] sw, [17:12] ne, [23:18] nw
- bus_vref_e_vrefgen_en, bus_vref_w_vrefgen_en  out  1 each
- bus_vref_e_ref_sel, bus_vref_w_ref_sel  out  5 each
- bus_user_ahb_enable  out  1
- bus_user_irqs_enable  out  16
- bus_sio_cfg  out  6
- bus_mgmt_select  in  1  asynchronous status from `sys_ctrl_regs`

## Operation
- Register map (word offsets), all RW fields reset to 0:
  - 0x00 MUXSPLIT: [23:0] = bus_muxsplit; [31:24] read 0
  - 0x04 VREF: [0] e_en, [1] w_en, [12:8] e_ref_sel, [20:16] w_ref_sel; other bits read 0
  - 0x08 USER: [0] user_ahb_enable, [31:16] user_irqs_enable
  - 0x0C SIO: [5:0] sio_cfg (RW), [8] mgmt_select synchronised (RO); writes to [8] ignored
  - 0x10 SCRATCH: [31:0] RW, no output
- Unimplemented bits: writes discarded, read 0.
- Byte lanes: lane mask from HSIZE/HADDR[1:0]; only enabled bytes of HWDATA update.
- Illegal transfer → ERROR, no register update: offset 0x14–0x1F, HSIZE>2, halfword with HADDR[0]=1, word with HADDR[1:0]≠0.
- FSM: IDLE → (valid legal addr phase) DATA → IDLE or DATA (back-to-back); valid illegal addr phase → ERR1 → ERR2 → IDLE. Valid addr phase = HSEL & HTRANS[1] & HREADY.
- Address-phase info (offset, lane mask, write) latched on acceptance; write commits at end of data phase (rising edge where HREADYOUT=1).
- HRDATA combinational from latched offset and current register contents during read data phase; 0 otherwise.

## Timing
- Reset (rst high at edge): all outputs and registers 0, FSM IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, sync flops 0.
- Legal read/write: zero wait states; write value visible on bus_* outputs the cycle after data phase.
- Write followed immediately by read of same register: read returns newly written data.
- ERROR: ERR1 HREADYOUT=0 HRESP=1; ERR2 HREADYOUT=1 HRESP=1. Address phases presented during ERR1 ignored (HREADY low); during ERR2 accepted normally.
- IDLE/BUSY transfers or HSEL=0: OKAY, no update, HRDATA=0.
- mgmt_select to SIO[8] latency: 2 cycles (MGMT_SYNC=1) or 1 cycle (0).
- rst asserted mid-transfer: aborts, state as reset on next edge; pending write discarded.

## Test plan
- Reset: after rst, read all five offsets → 0; HREADYOUT=1, HRESP=0; all bus_* outputs 0.
- Word write 0x00A5_5A5A to 0x00 → bus_muxsplit=0xA55A5A next cycle; readback 0x00A55A5A; write 0xFFFF_FFFF to 0x04 → readback 0x001F1F03.
- Byte write 0x3C to 0x0A (lane 2) after USER=0 → bus_user_irqs_enable=0x003C, bit0 unchanged; halfword 0xBEEF at 0x12 → SCRATCH=0xBEEF0000.
- Illegal: write to 0x14, halfword at 0x01, HSIZE=3 → each gives HREADYOUT 0 then 1 with HRESP=1 both cycles; all registers unchanged.
- Back-to-back write 0x15 to 0x0C then read 0x0C → HRDATA bits[5:0]=0x15 in next data phase; bus_sio_cfg=0x15.
- Toggle bus_mgmt_select 0→1 → SIO[8] reads 1 exactly 2 cycles later; write 0 to bit 8 has no effect.
